// File: rtl/inst_ram_loader.sv
// Writable 64-word instruction memory loaded from a byte stream (header = word count,
// then big-endian words written from address 0). Combinational fetch returns NOP while busy.
module inst_ram_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] a,
  output logic [WORD_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int REM_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                mem_we;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  wire xfer = rx_valid && rx_ready;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    word_d    = word_q;
    mem_we    = 1'b0;
    rx_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (xfer && rx_data != 8'd0) begin
          // Headers beyond the memory depth are clamped to a full-memory load
          rem_d     = (rx_data > 8'(DEPTH)) ? REM_W'(DEPTH) : REM_W'(rx_data);
          wr_addr_d = '0;
          cnt_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        rx_ready = 1'b1;
        if (xfer) begin
          word_d = {word_q[WORD_W-9:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        rem_d     = rem_q - REM_W'(1);
        state_d   = (rem_q == REM_W'(1)) ? DONE : LOAD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      word_q    <= word_d;
    end
  end

  // Reset clears the whole program so a half-loaded image can never be fetched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_addr_q] <= word_q;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign wr_addr = wr_addr_q;
  assign inst    = busy ? '0 : mem_q[a];
endmodule

// File: tb/tb_inst_ram_loader.sv
// Randomized bench for inst_ram_loader against an array-based model of the loaded memory.
module tb_inst_ram_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [5:0]  a;
  logic [31:0] inst;
  logic        busy;
  logic        done;
  logic [5:0]  wr_addr;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [64];
  logic [31:0] prog [64];
  int busy_cyc = 0, done_cnt = 0, bad_inst = 0;

  inst_ram_loader #(.ADDR_W(6), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .a(a), .inst(inst), .busy(busy), .done(done), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  // Cumulative observations; tasks compare deltas
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if ((busy && inst !== 32'h0) || (done && !busy)) bad_inst++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit junk);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      if (junk) rx_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    rx_data = b;
    checks++;
    if (!rx_ready) begin
      failures++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sweep_mem(input string name);
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      #1;
      checks++;
      if (inst !== model[i]) begin
        failures++;
        $display("FAIL %s_inst[%0d]: got %h required %h", name, i, inst, model[i]);
      end
    end
  endtask

  // Loads prog[0..n-1] with the given header; busy_exp<0 skips the busy-length check
  task automatic do_load(input string name, input logic [7:0] hdr, input int gap,
                         input bit junk, input int busy_exp);
    int n, b0, d0, i0, t;
    n  = (hdr > 8'd64) ? 64 : int'(hdr);
    b0 = busy_cyc; d0 = done_cnt; i0 = bad_inst;
    send_byte(hdr, 0, 1'b0);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) send_byte(prog[k][31-8*j -: 8], gap, junk);
      model[k] = prog[k];
    end
    t = 0;
    while (busy && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (busy) begin failures++; $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy); end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt - d0);
    end
    checks++;
    if (bad_inst != i0) begin
      failures++; $display("FAIL %s_inst_while_busy: got %0d bad cycles required 0", name, bad_inst - i0);
    end
    checks++;
    if (wr_addr !== 6'(n % 64)) begin
      failures++; $display("FAIL %s_wr_addr: got %h required %h", name, wr_addr, 6'(n % 64));
    end
    if (busy_exp >= 0) begin
      checks++;
      if (busy_cyc - b0 != busy_exp) begin
        failures++; $display("FAIL %s_busy_len: got %0d required %0d", name, busy_cyc - b0, busy_exp);
      end
    end
    sweep_mem(name);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    sweep_mem("reset");
    checks++;
    if ({rx_ready, busy, done} !== 3'b100 || wr_addr !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs: rdy/busy/done=%b wr_addr=%h required 100 00", {rx_ready, busy, done}, wr_addr);
    end
  endtask

  task automatic test_single_word();
    prog[0] = 32'h00100443;
    do_load("single", 8'h01, 0, 1'b0, 6);
  endtask

  task automatic test_gapped_17();
    for (int k = 0; k < 17; k++) prog[k] = $urandom;
    prog[1] = 32'h00100443; prog[11] = 32'h4800000E; prog[16] = 32'h40002485;
    do_load("gap17", 8'h11, 3, 1'b0, -1);
  endtask

  task automatic test_zero_header();
    int b0, d0;
    logic [5:0] wa;
    b0 = busy_cyc; d0 = done_cnt; wa = wr_addr;
    send_byte(8'h00, 0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy_cyc != b0 || done_cnt != d0 || busy !== 1'b0 || wr_addr !== wa) begin
      failures++;
      $display("FAIL zero_hdr: busy_cycles=%0d done=%0d wr_addr=%h required 0 0 %h",
               busy_cyc - b0, done_cnt - d0, wr_addr, wa);
    end
    sweep_mem("zero_hdr");
  endtask

  task automatic test_full_clamp();
    for (int k = 0; k < 64; k++) prog[k] = $urandom;
    do_load("full64", 8'hFF, 0, 1'b0, 5 * 64 + 1);
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b1 || wr_addr !== 6'd0) begin
      failures++;
      $display("FAIL midrst_async: busy=%b rx_ready=%b wr_addr=%h required 0 1 00", busy, rx_ready, wr_addr);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    sweep_mem("midrst");
    prog[0] = $urandom;
    do_load("after_rst", 8'h01, 0, 1'b0, 6);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) prog[k] = $urandom;
    do_load("backpressure", 8'h05, 0, 1'b1, 26);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; a = '0;
    #12 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_gapped_17();
    test_zero_header();
    test_full_clamp();
    test_reset_mid_word();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
